// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter branch direction predictor.
// Define BP_GSHARE_EN to XOR a global history register into the index.
module branch_predictor #(
   parameter int BIT      = 32,
   parameter int IDX_BITS = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BIT-1:0]      f_pc,
   output logic [IDX_BITS-1:0] f_idx,
   output logic                pred_taken,
   input  logic                ex_valid,
   input  logic                ex_is_br,
   input  logic [IDX_BITS-1:0] ex_idx,
   input  logic                ex_pred_taken,
   input  logic                comp_res,
   output logic                mispredict,
   output logic [31:0]         br_count,
   output logic [31:0]         miss_count
);

   localparam int DEPTH = 1 << IDX_BITS;

   logic [1:0]          tbl [DEPTH];
   logic                upd;
   logic                miss;
   logic [IDX_BITS-1:0] pc_idx;
   logic                unused_pc;

   assign upd       = ex_valid & ex_is_br;
   assign miss      = comp_res ^ ex_pred_taken;
   assign pc_idx    = f_pc[IDX_BITS+1:2];
   assign unused_pc = ^{f_pc[BIT-1:IDX_BITS+2], f_pc[1:0]};

`ifdef BP_GSHARE_EN
   logic [IDX_BITS-1:0] ghr;

   // Shift each resolved outcome into the global history
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr <= '0;
      end else if (upd) begin
         ghr <= {ghr[IDX_BITS-2:0], comp_res};
      end
   end

   assign f_idx = pc_idx ^ ghr;
`else
   assign f_idx = pc_idx;
`endif

   // Prediction reads the pre-update counter; no bypass
   assign pred_taken = tbl[f_idx][1];

   // Train the addressed counter toward the resolved direction
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl[i] <= 2'b01;
         end
      end else if (upd) begin
         if (comp_res) begin
            if (tbl[ex_idx] != 2'b11) begin
               tbl[ex_idx] <= tbl[ex_idx] + 2'd1;
            end
         end else begin
            if (tbl[ex_idx] != 2'b00) begin
               tbl[ex_idx] <= tbl[ex_idx] - 2'd1;
            end
         end
      end
   end

   // Statistics and the one-cycle mispredict pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         mispredict <= 1'b0;
         br_count   <= '0;
         miss_count <= '0;
      end else begin
         mispredict <= upd & miss;
         if (upd) begin
            br_count <= br_count + 32'd1;
            if (miss) begin
               miss_count <= miss_count + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks against a
// behavioural counter-table model of the predictor.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] f_pc;
   logic [5:0]  f_idx;
   logic        pred_taken;
   logic        ex_valid;
   logic        ex_is_br;
   logic [5:0]  ex_idx;
   logic        ex_pred_taken;
   logic        comp_res;
   logic        mispredict;
   logic [31:0] br_count;
   logic [31:0] miss_count;

   int          vectors;
   int          miscompares;

   int          cnt [64];
   int          ghr_m;
   logic [31:0] br_m;
   logic [31:0] miss_m;
   logic        misp_m;

   branch_predictor #(.BIT(32), .IDX_BITS(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .f_pc          (f_pc),
      .f_idx         (f_idx),
      .pred_taken    (pred_taken),
      .ex_valid      (ex_valid),
      .ex_is_br      (ex_is_br),
      .ex_idx        (ex_idx),
      .ex_pred_taken (ex_pred_taken),
      .comp_res      (comp_res),
      .mispredict    (mispredict),
      .br_count      (br_count),
      .miss_count    (miss_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_idx(input logic [31:0] pc);
      int i;
      i = int'((pc >> 2) & 32'h3f);
`ifdef BP_GSHARE_EN
      i = i ^ ghr_m;
`endif
      return i;
   endfunction

   function automatic logic model_pred(input int i);
      return cnt[i] >= 2;
   endfunction

   // One clock: drive, check fetch-side outputs, clock, check state.
   task automatic cycle(input logic r, input logic [31:0] pc,
                        input logic v, input logic b,
                        input logic [5:0] idx, input logic pt,
                        input logic res);
      int fi;
      @(negedge clk);
      rst           = r;
      f_pc          = pc;
      ex_valid      = v;
      ex_is_br      = b;
      ex_idx        = idx;
      ex_pred_taken = pt;
      comp_res      = res;
      #1;
      fi = model_idx(pc);
      if (!r) begin
         chk("f_idx", 32'(f_idx), 32'(fi));
         chk("pred_taken", 32'(pred_taken), 32'(model_pred(fi)));
      end
      @(posedge clk);
      if (r) begin
         foreach (cnt[k]) cnt[k] = 1;
         br_m   = 0;
         miss_m = 0;
         misp_m = 0;
         ghr_m  = 0;
      end else begin
         misp_m = 0;
         if (v && b) begin
            if (res) cnt[idx] = (cnt[idx] == 3) ? 3 : cnt[idx] + 1;
            else     cnt[idx] = (cnt[idx] == 0) ? 0 : cnt[idx] - 1;
            br_m = br_m + 1;
            if (res != pt) begin
               miss_m = miss_m + 1;
               misp_m = 1;
            end
            ghr_m = ((ghr_m << 1) | int'(res)) & 63;
         end
      end
      #1;
      chk("mispredict", 32'(mispredict), 32'(misp_m));
      chk("br_count", br_count, br_m);
      chk("miss_count", miss_count, miss_m);
   endtask

   initial begin
      logic [31:0] pc;
      logic [5:0]  ri;
      logic        pt;
      logic        res;
      logic        v;
      logic        b;
      clk           = 1'b0;
      rst           = 1'b1;
      f_pc          = '0;
      ex_valid      = 1'b0;
      ex_is_br      = 1'b0;
      ex_idx        = '0;
      ex_pred_taken = 1'b0;
      comp_res      = 1'b0;
      vectors       = 0;
      miscompares   = 0;
      foreach (cnt[k]) cnt[k] = 1;
      ghr_m  = 0;
      br_m   = 0;
      miss_m = 0;
      misp_m = 0;

      // Reset with a branch update presented: update must be discarded
      cycle(1'b1, 32'h100, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1);
      cycle(1'b1, 32'h100, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1);
      cycle(1'b0, 32'h100, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      chk("rst_pred", 32'(pred_taken), 32'd0);
      chk("rst_br", br_count, 32'd0);

      // First mispredict on index 0
      cycle(1'b0, 32'h100, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1);
      chk("miss_pulse", 32'(mispredict), 32'd1);
      chk("miss_cnt1", miss_count, 32'd1);
`ifndef BP_GSHARE_EN
      chk("idx0_trained", 32'(pred_taken), 32'd1);
`endif
      cycle(1'b0, 32'h100, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      chk("miss_pulse_end", 32'(mispredict), 32'd0);

      // Saturate index 5 then walk it back; fetch 0x14 alongside
      for (int k = 0; k < 6; k++) begin
         res = (k < 4);
         pt  = model_pred(5);
         cycle(1'b0, 32'h14, 1'b1, 1'b1, 6'd5, pt, res);
      end
`ifndef BP_GSHARE_EN
      chk("idx5_final", 32'(pred_taken), 32'd0);
`endif

      // Randomised traffic with occasional reset
      for (int n = 0; n < 400; n++) begin
         pc  = $urandom;
         ri  = 6'($urandom_range(0, 63));
         v   = ($urandom_range(0, 3) != 0);
         b   = ($urandom_range(0, 3) != 0);
         res = 1'($urandom);
         if ($urandom_range(0, 1) == 0) pt = model_pred(int'(ri));
         else                           pt = 1'($urandom);
         cycle(($urandom_range(0, 59) == 0), pc, v, b, ri, pt, res);
      end

      // Mid-operation reset discards training on every entry
      cycle(1'b1, 32'h0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1);
      for (int k = 0; k < 64; k++) begin
         cycle(1'b0, 32'(k * 4), 1'b0, 1'b1, 6'd0, 1'b0, 1'b1);
         chk("post_rst_pred", 32'(pred_taken), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
